// File: rtl/mem_access_seq_if.sv
// Request/memory/response bundle for mem_access_seq.
// rsp_cause exists only when MEMSEQ_EXC_CAUSE_EN is defined.
interface mem_access_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_excpt;
    logic              busy;
`ifdef MEMSEQ_EXC_CAUSE_EN
    logic [1:0]        rsp_cause;
`endif

    modport slave (
        input  req_valid, req_op, req_size, req_addr, req_wdata, mem_rdata,
`ifdef MEMSEQ_EXC_CAUSE_EN
        output rsp_cause,
`endif
        output req_ready, mem_addr, mem_wr, mem_wdata, rsp_valid, rsp_data,
               rsp_excpt, busy
    );

    modport master (
        output req_valid, req_op, req_size, req_addr, req_wdata, mem_rdata,
`ifdef MEMSEQ_EXC_CAUSE_EN
        input  rsp_cause,
`endif
        input  req_ready, mem_addr, mem_wr, mem_wdata, rsp_valid, rsp_data,
               rsp_excpt, busy
    );
endinterface

// File: rtl/mem_access_seq.sv
// Memory-access sequencer: fetch/load/store with MEM_LATENCY wait, sub-word RMW, exceptions.
// Optional MEMSEQ_EXC_CAUSE_EN adds rsp_cause on the interface.
module mem_access_seq #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_EXC   = 3'd4;

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_RSVD  = 2'b11;

    localparam int              CNT_W  = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_RD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
    endfunction

    function automatic logic reserved(input logic [1:0] op, input logic [1:0] size);
        return (op == OP_RSVD) || (size == SZ_RSVD) || (op == OP_FETCH && size != SZ_WORD);
    endfunction

    function automatic logic [DATA_W-1:0] load_fmt(input logic [1:0] size, input logic [1:0] a,
                                                    input logic [DATA_W-1:0] rd);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = rd >> {a, 3'b000};
        case (size)
            SZ_BYTE: res = {{(DATA_W-8){sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{(DATA_W-16){sh[15]}}, sh[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    // Only the addressed lane is replaced; the mask confines wd to that lane.
    function automatic logic [DATA_W-1:0] merge(input logic [1:0] size, input logic [1:0] a,
                                                 input logic [DATA_W-1:0] rd, input logic [15:0] wd);
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] w;
        m = (size == SZ_BYTE) ? DATA_W'(16'h00FF) : DATA_W'(16'hFFFF);
        m = m << {a, 3'b000};
        w = DATA_W'(wd) << {a, 3'b000};
        return (rd & ~m) | (w & m);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d, size_q, size_d, a_q, a_d;
    logic [15:0]       wd_q, wd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              mem_wr_q, mem_wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_excpt_q, rsp_excpt_d;
    logic              exc_in;

    assign exc_in = misaligned(bus.req_size, bus.req_addr[1:0]) || reserved(bus.req_op, bus.req_size);

    // Word stores and exceptions spend one silent cycle (cnt=1) so every response
    // and strobe leaves a register on a state edge with a fixed latency.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        size_d      = size_q;
        a_d         = a_q;
        wd_d        = wd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_data_d  = '0;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                op_d   = bus.req_op;
                size_d = bus.req_size;
                a_d    = bus.req_addr[1:0];
                wd_d   = bus.req_wdata[15:0];
                if (exc_in) begin
                    state_d = S_EXC;
                    cnt_d   = CNT_1;
                end else begin
                    mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    if (bus.req_op == OP_STORE && bus.req_size == SZ_WORD) begin
                        state_d     = S_WRITE;
                        cnt_d       = CNT_1;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = CNT_RD;
                    end
                end
            end
            S_READ: if (cnt_q == '0) begin
                if (op_q == OP_STORE) begin
                    state_d     = S_WRITE;
                    mem_wdata_d = merge(size_q, a_q, bus.mem_rdata, wd_q);
                end else begin
                    state_d    = S_RESP;
                    rsp_data_d = load_fmt(size_q, a_q, bus.mem_rdata);
                end
            end else begin
                cnt_d = cnt_q - CNT_1;
            end
            S_WRITE: if (cnt_q == '0) state_d = S_RESP;
                     else             cnt_d   = cnt_q - CNT_1;
            S_EXC:   if (cnt_q == '0) state_d = S_IDLE;
                     else             cnt_d   = cnt_q - CNT_1;
            default: state_d = S_IDLE;
        endcase
        mem_wr_d    = (state_d == S_WRITE) && (cnt_d == '0);
        rsp_excpt_d = (state_d == S_EXC) && (cnt_d == '0);
        rsp_valid_d = (state_d == S_RESP) || rsp_excpt_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            size_q      <= '0;
            a_q         <= '0;
            wd_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_data_q  <= '0;
            mem_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_excpt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            size_q      <= size_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_data_q  <= rsp_data_d;
            mem_wr_q    <= mem_wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_excpt_q <= rsp_excpt_d;
        end
    end

`ifdef MEMSEQ_EXC_CAUSE_EN
    logic [1:0] cause_q, cause_d;

    // Misaligned wins over reserved when both apply.
    always_comb begin
        cause_d = 2'b00;
        if (rsp_excpt_d) cause_d = misaligned(size_q, a_q) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cause_q <= 2'b00;
        else        cause_q <= cause_d;
    end

    assign bus.rsp_cause = cause_q;
`endif

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_excpt = rsp_excpt_q;
endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: one instance at MEM_LATENCY=2, one at MEM_LATENCY=5.
module tb_mem_access_seq;
    localparam logic [1:0] OP_FETCH = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_RSVD = 2'b11;
    localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;

    logic clk = 1'b0;
    logic rst2_n, rst5_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_access_seq_if #(.ADDR_W(32), .DATA_W(32)) if2 ();
    mem_access_seq_if #(.ADDR_W(32), .DATA_W(32)) if5 ();

    mem_access_seq #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut2 (.clk(clk), .reset(rst2_n), .bus(if2));
    mem_access_seq #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(5)) dut5 (.clk(clk), .reset(rst5_n), .bus(if5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds req_valid until the L=2 instance is ready, then returns just after the accept edge.
    task automatic req2(input logic [1:0] op, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
        logic acc;
        acc = 1'b0;
        if2.req_op    = op;
        if2.req_size  = size;
        if2.req_addr  = addr;
        if2.req_wdata = wdata;
        if2.req_valid = 1'b1;
        for (int i = 0; i < 8 && !acc; i++) begin
            acc = if2.req_ready;
            tick();
        end
        if2.req_valid = 1'b0;
        chk("accept", acc, 1'b1);
    endtask

    task automatic rd2(input string tag, input logic [1:0] op, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        req2(op, size, addr, 32'h0);
        chk({tag, ":addr"}, if2.mem_addr, exp_addr);
        tick();
        chk({tag, ":early"}, if2.rsp_valid, 1'b0);
        tick();
        chk({tag, ":vld"}, if2.rsp_valid, 1'b1);
        chk({tag, ":data"}, if2.rsp_data, exp_data);
        chk({tag, ":exc"}, if2.rsp_excpt, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1);
    end

    initial begin
        rst2_n = 1'b0; rst5_n = 1'b0;
        if2.req_valid = 1'b0; if2.req_op = '0; if2.req_size = '0; if2.req_addr = '0;
        if2.req_wdata = '0; if2.mem_rdata = '0;
        if5.req_valid = 1'b0; if5.req_op = '0; if5.req_size = '0; if5.req_addr = '0;
        if5.req_wdata = '0; if5.mem_rdata = '0;
        #12;
        chk("rst:ready", if2.req_ready, 1'b1);
        chk("rst:busy", if2.busy, 1'b0);
        chk("rst:addr", if2.mem_addr, 32'h0);
        chk("rst:wr", if2.mem_wr, 1'b0);
        chk("rst:wdata", if2.mem_wdata, 32'h0);
        chk("rst:vld", if2.rsp_valid, 1'b0);
        chk("rst:data", if2.rsp_data, 32'h0);
        chk("rst:exc", if2.rsp_excpt, 1'b0);
`ifdef MEMSEQ_EXC_CAUSE_EN
        chk("rst:cause", if2.rsp_cause, 2'b00);
`endif
        rst2_n = 1'b1; rst5_n = 1'b1;
        tick();

        // T1: word load, latency 2
        if2.mem_rdata = 32'hDEADBEEF;
        req2(OP_LOAD, SZ_WORD, 32'h100, 32'h0);
        chk("t1:busy", if2.busy, 1'b1);
        chk("t1:ready", if2.req_ready, 1'b0);
        chk("t1:addr", if2.mem_addr, 32'h100);
        chk("t1:wr", if2.mem_wr, 1'b0);
        tick();
        chk("t1:early", if2.rsp_valid, 1'b0);
        tick();
        chk("t1:vld", if2.rsp_valid, 1'b1);
        chk("t1:data", if2.rsp_data, 32'hDEADBEEF);
        chk("t1:exc", if2.rsp_excpt, 1'b0);
`ifdef MEMSEQ_EXC_CAUSE_EN
        chk("t1:cause", if2.rsp_cause, 2'b00);
`endif

        // T2: sign-extended sub-word loads, plus a positive byte and a fetch
        if2.mem_rdata = 32'h80AA5511;
        rd2("t2:lb103", OP_LOAD, SZ_BYTE, 32'h103, 32'h100, 32'hFFFFFF80);
        rd2("t2:lh102", OP_LOAD, SZ_HALF, 32'h102, 32'h100, 32'hFFFF80AA);
        rd2("t2:lb101", OP_LOAD, SZ_BYTE, 32'h101, 32'h100, 32'h00000055);
        rd2("t2:lh100", OP_LOAD, SZ_HALF, 32'h100, 32'h100, 32'h00005511);
        rd2("t2:fetch", OP_FETCH, SZ_WORD, 32'h204, 32'h204, 32'h80AA5511);
        tick();
        chk("t2:vld_off", if2.rsp_valid, 1'b0);
        chk("t2:idle", if2.busy, 1'b0);

        // T3: byte RMW, half RMW, word store
        if2.mem_rdata = 32'h11223344;
        req2(OP_STORE, SZ_BYTE, 32'h101, 32'hABCDEF77);
        chk("t3b:wr0", if2.mem_wr, 1'b0);
        chk("t3b:addr", if2.mem_addr, 32'h100);
        tick();
        chk("t3b:wr1", if2.mem_wr, 1'b0);
        tick();
        chk("t3b:wr2", if2.mem_wr, 1'b1);
        chk("t3b:wdata", if2.mem_wdata, 32'h11227744);
        chk("t3b:vld2", if2.rsp_valid, 1'b0);
        tick();
        chk("t3b:wr3", if2.mem_wr, 1'b0);
        chk("t3b:vld3", if2.rsp_valid, 1'b1);
        chk("t3b:data", if2.rsp_data, 32'h0);
        chk("t3b:exc", if2.rsp_excpt, 1'b0);

        req2(OP_STORE, SZ_HALF, 32'h102, 32'h1234BEEF);
        tick();
        tick();
        chk("t3h:wr", if2.mem_wr, 1'b1);
        chk("t3h:wdata", if2.mem_wdata, 32'hBEEF3344);
        tick();
        chk("t3h:vld", if2.rsp_valid, 1'b1);

        req2(OP_STORE, SZ_WORD, 32'h104, 32'hCAFEF00D);
        chk("t3w:wr0", if2.mem_wr, 1'b0);
        chk("t3w:addr", if2.mem_addr, 32'h104);
        tick();
        chk("t3w:wr1", if2.mem_wr, 1'b1);
        chk("t3w:wdata", if2.mem_wdata, 32'hCAFEF00D);
        chk("t3w:vld1", if2.rsp_valid, 1'b0);
        tick();
        chk("t3w:vld2", if2.rsp_valid, 1'b1);
        chk("t3w:wr2", if2.mem_wr, 1'b0);

        // T4: exceptions
        req2(OP_STORE, SZ_HALF, 32'h101, 32'h0);
        chk("t4a:busy", if2.busy, 1'b1);
        chk("t4a:vld0", if2.rsp_valid, 1'b0);
        chk("t4a:wr0", if2.mem_wr, 1'b0);
        tick();
        chk("t4a:vld", if2.rsp_valid, 1'b1);
        chk("t4a:exc", if2.rsp_excpt, 1'b1);
        chk("t4a:data", if2.rsp_data, 32'h0);
        chk("t4a:wr", if2.mem_wr, 1'b0);
        chk("t4a:addr", if2.mem_addr, 32'h104);
`ifdef MEMSEQ_EXC_CAUSE_EN
        chk("t4a:cause", if2.rsp_cause, 2'b01);
`endif
        tick();
        chk("t4a:vld_off", if2.rsp_valid, 1'b0);
        chk("t4a:exc_off", if2.rsp_excpt, 1'b0);
        chk("t4a:idle", if2.busy, 1'b0);

        req2(OP_FETCH, SZ_BYTE, 32'h200, 32'h0);
        tick();
        chk("t4b:exc", if2.rsp_excpt, 1'b1);
        chk("t4b:addr", if2.mem_addr, 32'h104);
`ifdef MEMSEQ_EXC_CAUSE_EN
        chk("t4b:cause", if2.rsp_cause, 2'b10);
`endif
        req2(OP_RSVD, SZ_WORD, 32'h101, 32'h0);
        tick();
        chk("t4c:exc", if2.rsp_excpt, 1'b1);
`ifdef MEMSEQ_EXC_CAUSE_EN
        chk("t4c:cause", if2.rsp_cause, 2'b01);
`endif
        req2(OP_LOAD, SZ_WORD, 32'h102, 32'h0);
        tick();
        chk("t4d:exc", if2.rsp_excpt, 1'b1);

        // T5: asynchronous reset while the write strobe is high
        req2(OP_STORE, SZ_WORD, 32'h108, 32'h55AA55AA);
        tick();
        chk("t5:wr_hi", if2.mem_wr, 1'b1);
        #2 rst2_n = 1'b0;
        #1;
        chk("t5:wr_drop", if2.mem_wr, 1'b0);
        chk("t5:busy", if2.busy, 1'b0);
        chk("t5:ready", if2.req_ready, 1'b1);
        chk("t5:addr", if2.mem_addr, 32'h0);
        #3 rst2_n = 1'b1;
        tick();
        chk("t5:no_vld", if2.rsp_valid, 1'b0);
        chk("t5:idle", if2.busy, 1'b0);
        if2.mem_rdata = 32'h12345678;
        rd2("t5:ld", OP_LOAD, SZ_WORD, 32'h100, 32'h100, 32'h12345678);

        // T6: L=5 load, store request held during busy, accepted once ready
        if5.mem_rdata = 32'hA5A5A5A5;
        if5.req_op = OP_LOAD; if5.req_size = SZ_WORD; if5.req_addr = 32'h300; if5.req_valid = 1'b1;
        tick();
        chk("t6:busy", if5.busy, 1'b1);
        if5.req_op = OP_STORE; if5.req_addr = 32'h304; if5.req_wdata = 32'h0F0F0F0F;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t6:wait_vld", if5.rsp_valid, 1'b0);
            chk("t6:wait_addr", if5.mem_addr, 32'h300);
            chk("t6:wait_wr", if5.mem_wr, 1'b0);
        end
        tick();
        chk("t6:vld5", if5.rsp_valid, 1'b1);
        chk("t6:data", if5.rsp_data, 32'hA5A5A5A5);
        chk("t6:ready_resp", if5.req_ready, 1'b0);
        tick();
        chk("t6:ready", if5.req_ready, 1'b1);
        chk("t6:vld_off", if5.rsp_valid, 1'b0);
        tick();
        if5.req_valid = 1'b0;
        chk("t6:st_busy", if5.busy, 1'b1);
        chk("t6:st_addr", if5.mem_addr, 32'h304);
        chk("t6:st_wr0", if5.mem_wr, 1'b0);
        tick();
        chk("t6:st_wr1", if5.mem_wr, 1'b1);
        chk("t6:st_wdata", if5.mem_wdata, 32'h0F0F0F0F);
        tick();
        chk("t6:st_vld", if5.rsp_valid, 1'b1);
        chk("t6:st_data", if5.rsp_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
